// File: rtl/memory_stage.sv
// memory_stage
// Memory stage of the pipeline. It holds the EX/MEM pipeline register, a
// word-addressed data memory and the MEM/WB pipeline register, and it selects
// the write-back result.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   ALUOutE             ALU result from execute (byte address for lw/sw)
//   WriteDataE          store data from execute
//   WriteRegE           destination register from execute
//   RegWriteE,
//   MemtoRegE,
//   MemWriteE           E-stage controls
//   ALUOutM             registered ALU result, used for forwarding
//   WriteRegM,
//   RegWriteM           M-stage destination and write enable, for the hazard unit
//   MemFaultM           the current M access is misaligned or out of range
//   FaultSticky         latched fault flag, cleared only by rst
//   ResultW             write-back value
//   WriteRegW,
//   RegWriteW           W-stage destination and write enable
//
// ADDR_BITS sets the word-index width and must be at most 29, so that the
// upper-bit slice used by the range check is never empty.
module memory_stage #(
  parameter int ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteRegE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  output logic [31:0] ALUOutM,
  output logic [4:0]  WriteRegM,
  output logic        RegWriteM,
  output logic        MemFaultM,
  output logic        FaultSticky,
  output logic [31:0] ResultW,
  output logic [4:0]  WriteRegW,
  output logic        RegWriteW
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0]          aluOutM_q;
  logic [31:0]          writeDataM_q;
  logic [4:0]           writeRegM_q;
  logic                 regWriteM_q;
  logic                 memtoRegM_q;
  logic                 memWriteM_q;

  logic [31:0]          aluOutW_q;
  logic [31:0]          readDataW_q;
  logic [4:0]           writeRegW_q;
  logic                 regWriteW_q;
  logic                 memtoRegW_q;

  logic                 faultSticky_q;
  logic                 faultSticky_d;

  logic [31:0]          mem [DEPTH];

  logic [ADDR_BITS-1:0] memIndex;
  logic                 memAccess;
  logic                 misaligned;
  logic                 outOfRange;
  logic                 memFault;
  logic [31:0]          readDataM;

  // A fault is raised only by a load or a store. Any address whose bits lie
  // above the word index is out of range, so the memory never aliases.
  assign memIndex   = aluOutM_q[ADDR_BITS+1:2];
  assign memAccess  = memWriteM_q | memtoRegM_q;
  assign misaligned = (aluOutM_q[1:0] != 2'b00);
  assign outOfRange = (aluOutM_q[31:ADDR_BITS+2] != '0);
  assign memFault   = memAccess & (misaligned | outOfRange);

  // Asynchronous read. A faulted load returns zero in place of the memory word.
  assign readDataM = memFault ? 32'd0 : mem[memIndex];

  // EX/MEM pipeline register. There is no stall or flush input, because
  // upstream inserts bubbles as all-zero controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      aluOutM_q    <= '0;
      writeDataM_q <= '0;
      writeRegM_q  <= '0;
      regWriteM_q  <= 1'b0;
      memtoRegM_q  <= 1'b0;
      memWriteM_q  <= 1'b0;
    end else begin
      aluOutM_q    <= ALUOutE;
      writeDataM_q <= WriteDataE;
      writeRegM_q  <= WriteRegE;
      regWriteM_q  <= RegWriteE;
      memtoRegM_q  <= MemtoRegE;
      memWriteM_q  <= MemWriteE;
    end
  end

  // The data memory is never cleared. A store commits at the edge that moves
  // it into W, so a load that follows it directly reads the new word without
  // a bypass path. A reset edge suppresses the store that is in M.
  always_ff @(posedge clk) begin
    if (!rst && memWriteM_q && !memFault) begin
      mem[memIndex] <= writeDataM_q;
    end
  end

  // The fault flag stays set until reset once any faulting access reaches M.
  always_comb begin
    faultSticky_d = faultSticky_q | memFault;
  end

  // MEM/WB pipeline register and the sticky fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      aluOutW_q     <= '0;
      readDataW_q   <= '0;
      writeRegW_q   <= '0;
      regWriteW_q   <= 1'b0;
      memtoRegW_q   <= 1'b0;
      faultSticky_q <= 1'b0;
    end else begin
      aluOutW_q     <= aluOutM_q;
      readDataW_q   <= readDataM;
      writeRegW_q   <= writeRegM_q;
      regWriteW_q   <= regWriteM_q;
      memtoRegW_q   <= memtoRegM_q;
      faultSticky_q <= faultSticky_d;
    end
  end

  assign ALUOutM     = aluOutM_q;
  assign WriteRegM   = writeRegM_q;
  assign RegWriteM   = regWriteM_q;
  assign MemFaultM   = memFault;
  assign FaultSticky = faultSticky_q;
  assign ResultW     = memtoRegW_q ? readDataW_q : aluOutW_q;
  assign WriteRegW   = writeRegW_q;
  assign RegWriteW   = regWriteW_q;

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage downstream of the execute stage: holds the EX/MEM pipeline register, the word-addressed data memory and the MEM/WB pipeline register, and selects the write-back result. It consumes ALUOutE, WriteDataE and WriteRegE plus the E-stage memory and register-write controls. It returns ALUOutM and ResultW to the execute-stage forwarding muxes, and returns WriteRegM/W and RegWriteM/W to the hazard unit.

## Interface
- ADDR_BITS, 6, word-index width; data memory holds 2^ADDR_BITS 32-bit words
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ALUOutE  in  32  ALU result from execute (memory byte address for lw/sw)
- WriteDataE  in  32  forwarded store data from execute
- WriteRegE  in  5  destination register from execute
- RegWriteE, MemtoRegE, MemWriteE  in  1 each  E-stage controls
- ALUOutM  out  32  registered ALU result (forwarding source)
- WriteRegM  out  5  registered destination register
- RegWriteM  out  1  registered register-write enable
- MemFaultM  out  1  combinational: current M access is a misaligned or out-of-range load/store
- FaultSticky  out  1  latched fault flag; cleared only by rst
- ResultW  out  32  write-back value
- WriteRegW  out  5  W-stage destination register
- RegWriteW  out  1  W-stage register-write enable

## Operation
- EX/MEM register: on each edge, captures ALUOutE, WriteDataE, WriteRegE, RegWriteE, MemtoRegE, MemWriteE. No stall or flush input; bubbles arrive as all-zero controls from upstream.
- Data memory: array of 2^ADDR_BITS x 32.
  - Index = ALUOutM[ADDR_BITS+1:2].
  - Read is asynchronous: ReadDataM = mem[index].
  - Write happens on the rising edge when MemWriteM=1 and the access is not faulted.
  - Memory contents are not cleared by rst.
- Fault: MemFaultM = (MemWriteM | MemtoRegM) & (ALUOutM[1:0]!=0 | ALUOutM[31:ADDR_BITS+2]!=0).
  - Faulted stores are dropped.
  - Faulted loads return 0 as ReadDataM.
- FaultSticky: set on any edge where MemFaultM=1; held until rst.
- MEM/WB register: on each edge, captures ALUOutM, ReadDataM, WriteRegM, RegWriteM, MemtoRegM.
- ResultW = MemtoRegW ? ReadDataW : ALUOutW.
- Non-memory instructions (MemWriteM=0, MemtoRegM=0) never fault, whatever the value of ALUOutM.

## Timing
- Reset: on an edge with rst=1, every EX/MEM and MEM/WB register clears to 0 and FaultSticky clears to 0.
  - After reset: ALUOutM=0, WriteRegM=0, RegWriteM=0, ResultW=0, WriteRegW=0, RegWriteW=0, MemFaultM=0, FaultSticky=0.
  - rst has priority over every capture and over memory writes. A store in M during a reset edge is not performed.
- Latency:
  - E-stage values appear on the M outputs 1 cycle after the capturing edge.
  - They reach ResultW, WriteRegW and RegWriteW 2 cycles after that edge.
- Store followed by load to the same word: the store commits at the edge that moves it to W. The following load, now in M, reads the new value in that same cycle. No bypass is required.
- Write-back ordering: ResultW is valid for the whole W cycle. The register file writes it in W.
- Reset mid-operation: in-flight instructions in M and W are discarded (RegWrite cleared). Memory keeps all previously committed stores.
- Address aliasing: the upper-bit check makes every address at or beyond 4*2^ADDR_BITS fault, so no aliasing occurs.

## Test plan
- Reset then idle: hold rst=1 for 2 cycles -> every output is 0. Release rst with all E inputs 0 -> outputs stay 0.
- Store then load:
  - Cycle 0: sw with ALUOutE=0x10, WriteDataE=0xDEADBEEF, MemWriteE=1.
  - Cycle 1: lw with ALUOutE=0x10, MemtoRegE=1, RegWriteE=1, WriteRegE=8.
  - Required: 2 edges after the lw capture, ResultW=0xDEADBEEF, WriteRegW=8, RegWriteW=1.
- ALU pass-through: R-type with ALUOutE=0x1234, RegWriteE=1, WriteRegE=3, MemtoRegE=0.
  - Required: ALUOutM=0x1234 after 1 edge; ResultW=0x1234 and WriteRegW=3 after 2 edges.
- Misaligned store: sw to 0x12 with data 0x55 -> MemFaultM=1 during M, and FaultSticky=1 from the next edge. A later lw from 0x10 returns the value stored there before the sw (0xDEADBEEF if run after the store-then-load scenario), not 0x55.
- Out-of-range load: lw to 0x400 with ADDR_BITS=6 -> MemFaultM=1 and ResultW=0 in W.
- Reset mid-flight: lw with RegWriteE=1 in M, then assert rst for 1 edge -> RegWriteW=0 and ResultW=0 after that edge. Memory words written before the reset read back unchanged afterwards.
